// File: rtl/mesh_wormhole_packetizer_if.sv
// mesh_wormhole_packetizer_if: descriptor, payload, flit and drop signals of the wormhole packetizer
interface mesh_wormhole_packetizer_if #(
    parameter int ROW_N     = 3,
    parameter int COL_M     = 3,
    parameter int CHANNEL_W = 8,
    parameter int FLIT_ID_W = 2,
    parameter int LEN_W     = 4
);
    localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W;
    localparam int ROW_ADDR_W  = $clog2(ROW_N);
    localparam int COL_ADDR_W  = $clog2(COL_M);
    logic                   msg_vld_i;
    logic                   msg_rdy_o;
    logic [ROW_ADDR_W-1:0]  msg_dst_row_i;
    logic [COL_ADDR_W-1:0]  msg_dst_col_i;
    logic [LEN_W-1:0]       msg_len_i;
    logic                   pld_vld_i;
    logic                   pld_rdy_o;
    logic [FLIT_DATA_W-1:0] pld_data_i;
    logic                   flit_vld_o;
    logic                   flit_rdy_i;
    logic [CHANNEL_W-1:0]   flit_data_o;
    logic                   drop_o;
    modport slave (
        input  msg_vld_i, msg_dst_row_i, msg_dst_col_i, msg_len_i, pld_vld_i, pld_data_i, flit_rdy_i,
        output msg_rdy_o, pld_rdy_o, flit_vld_o, flit_data_o, drop_o
    );
    modport master (
        output msg_vld_i, msg_dst_row_i, msg_dst_col_i, msg_len_i, pld_vld_i, pld_data_i, flit_rdy_i,
        input  msg_rdy_o, pld_rdy_o, flit_vld_o, flit_data_o, drop_o
    );
endinterface

// File: rtl/mesh_wormhole_packetizer.sv
// mesh_wormhole_packetizer: turns a descriptor plus payload stream into HEAD/BODY/TAIL flits, dropping bad destinations
module mesh_wormhole_packetizer #(
    parameter int ROW_N     = 3,
    parameter int COL_M     = 3,
    parameter int CHANNEL_W = 8,
    parameter int FLIT_ID_W = 2,
    parameter int LEN_W     = 4
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    mesh_wormhole_packetizer_if.slave b
);
    localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W;
    localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(0);
    localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(1);
    localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(2);
    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_e;
    state_e               state_q, state_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic                 flit_vld_q, flit_vld_d;
    logic [CHANNEL_W-1:0] flit_data_q, flit_data_d;
    logic                 drop_q, drop_d;
    logic                 msg_rdy, pld_rdy, load_ok, dst_ok;
    assign load_ok = !flit_vld_q || b.flit_rdy_i;
    assign dst_ok  = int'(b.msg_dst_row_i) < ROW_N && int'(b.msg_dst_col_i) < COL_M;
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        flit_vld_d  = flit_vld_q && !b.flit_rdy_i;
        flit_data_d = flit_data_q;
        drop_d      = 1'b0;
        msg_rdy     = 1'b0;
        pld_rdy     = 1'b0;
        case (state_q)
            IDLE: begin
                msg_rdy = load_ok;
                if (b.msg_vld_i && msg_rdy) begin
                    rem_d   = b.msg_len_i;
                    state_d = dst_ok ? PAYLOAD : DROP;
                    drop_d  = !dst_ok;
                    if (dst_ok) begin
                        flit_vld_d  = 1'b1;
                        flit_data_d = {ID_HEAD, FLIT_DATA_W'({b.msg_dst_row_i, b.msg_dst_col_i})};
                    end
                end
            end
            PAYLOAD: begin
                pld_rdy = load_ok;
                if (b.pld_vld_i && pld_rdy) begin
                    flit_vld_d  = 1'b1;
                    flit_data_d = {(rem_q != '0) ? ID_BODY : ID_TAIL, b.pld_data_i};
                    rem_d       = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
                    state_d     = (rem_q != '0) ? PAYLOAD : IDLE;
                end
            end
            DROP: begin
                pld_rdy = 1'b1;
                if (b.pld_vld_i) begin
                    rem_d   = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
                    state_d = (rem_q != '0) ? DROP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            flit_vld_q  <= 1'b0;
            flit_data_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            flit_vld_q  <= flit_vld_d;
            flit_data_q <= flit_data_d;
            drop_q      <= drop_d;
        end
    end
    assign b.msg_rdy_o   = rst_ni && msg_rdy;
    assign b.pld_rdy_o   = rst_ni && pld_rdy;
    assign b.flit_vld_o  = flit_vld_q;
    assign b.flit_data_o = flit_data_q;
    assign b.drop_o      = drop_q;
endmodule

// File: tb/tb_mesh_wormhole_packetizer.sv
// tb_mesh_wormhole_packetizer: directed scoreboard bench for the wormhole packetizer
module tb_mesh_wormhole_packetizer;
    logic clk_i = 1'b0;
    logic rst_ni;
    int   pass_cnt = 0;
    int   chk_cnt = 0;
    int   cyc = 0;
    int   drops = 0;
    logic [7:0] sb[$];
    int   xq[$];
    mesh_wormhole_packetizer_if bus ();
    mesh_wormhole_packetizer dut (.clk_i(clk_i), .rst_ni(rst_ni), .b(bus));
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    always @(negedge clk_i) begin
        if (bus.drop_o) drops++;
        if (bus.flit_vld_o && bus.flit_rdy_i) begin
            xq.push_back(cyc);
            if (sb.size() == 0) check("extra_flit_vld", 32'(bus.flit_vld_o), 0);
            else check("flit", 32'(bus.flit_data_o), 32'(sb.pop_front()));
        end
    end
    function automatic logic [7:0] head_f(input logic [1:0] r, input logic [1:0] c);
        return {2'b00, 2'b00, r, c};
    endfunction
    task automatic msg(input logic [1:0] r, input logic [1:0] c, input logic [3:0] len);
        int n = 0;
        bus.msg_dst_row_i = r;
        bus.msg_dst_col_i = c;
        bus.msg_len_i = len;
        bus.msg_vld_i = 1'b1;
        while (!bus.msg_rdy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) check("msg_handshake", 32'(bus.msg_rdy_o), 1);
        @(posedge clk_i);
        #1 bus.msg_vld_i = 1'b0;
    endtask
    task automatic pld(input logic [5:0] w);
        int n = 0;
        bus.pld_data_i = w;
        bus.pld_vld_i = 1'b1;
        while (!bus.pld_rdy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) check("pld_handshake", 32'(bus.pld_rdy_o), 1);
        @(posedge clk_i);
        #1 bus.pld_vld_i = 1'b0;
    endtask
    task automatic send_pkt(input logic [1:0] r, input logic [1:0] c, input int len, input logic [5:0] base);
        sb.push_back(head_f(r, c));
        for (int i = 0; i <= len; i++) sb.push_back({(i == len) ? 2'b10 : 2'b01, 6'(base + 6'(i))});
        msg(r, c, 4'(len));
        for (int i = 0; i <= len; i++) pld(6'(base + 6'(i)));
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        rst_ni = 1'b0;
        bus.msg_vld_i = 1'b0;
        bus.msg_dst_row_i = '0;
        bus.msg_dst_col_i = '0;
        bus.msg_len_i = '0;
        bus.pld_vld_i = 1'b0;
        bus.pld_data_i = '0;
        bus.flit_rdy_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_flit_vld", 32'(bus.flit_vld_o), 0);
        check("rst_flit_data", 32'(bus.flit_data_o), 0);
        check("rst_drop", 32'(bus.drop_o), 0);
        check("rst_msg_rdy", 32'(bus.msg_rdy_o), 0);
        check("rst_pld_rdy", 32'(bus.pld_rdy_o), 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_msg_rdy", 32'(bus.msg_rdy_o), 1);
        check("idle_pld_rdy", 32'(bus.pld_rdy_o), 0);
        // basic packet: head one cycle after the descriptor, then one flit per cycle
        xq.delete();
        sb.push_back(8'h09); sb.push_back(8'h55); sb.push_back(8'h6A); sb.push_back(8'hBF);
        msg(2'd2, 2'd1, 4'd2);
        @(negedge clk_i);
        check("basic_head_vld", 32'(bus.flit_vld_o), 1);
        check("basic_head_data", 32'(bus.flit_data_o), 32'h09);
        pld(6'h15); pld(6'h2A); pld(6'h3F);
        drain();
        check("basic_count", xq.size(), 4);
        if (xq.size() == 4) check("basic_span", xq[3] - xq[0], 3);
        // single-word packet; descriptor ready returns right after the tail load
        sb.push_back(8'h00); sb.push_back(8'h81);
        msg(2'd0, 2'd0, 4'd0);
        pld(6'h01);
        @(negedge clk_i);
        check("single_msg_rdy", 32'(bus.msg_rdy_o), 1);
        drain();
        // backpressure: body0 held for five cycles
        sb.push_back(8'h06);
        for (int i = 0; i < 3; i++) sb.push_back({2'b01, 6'(6'h10 + 6'(i))});
        sb.push_back(8'h93);
        msg(2'd1, 2'd2, 4'd3);
        pld(6'h10);
        bus.flit_rdy_i = 1'b0;
        bus.pld_data_i = 6'h11;
        bus.pld_vld_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_vld", 32'(bus.flit_vld_o), 1);
            check("bp_data", 32'(bus.flit_data_o), 32'h50);
            check("bp_pld_rdy", 32'(bus.pld_rdy_o), 0);
            check("bp_msg_rdy", 32'(bus.msg_rdy_o), 0);
        end
        @(posedge clk_i);
        #1 bus.flit_rdy_i = 1'b1;
        pld(6'h11); pld(6'h12); pld(6'h13);
        drain();
        // drop: row 3 is outside the 3x3 mesh
        drops = 0;
        msg(2'd3, 2'd0, 4'd1);
        @(negedge clk_i);
        check("drop_pulse", 32'(bus.drop_o), 1);
        check("drop_flit_vld", 32'(bus.flit_vld_o), 0);
        pld(6'h20); pld(6'h21);
        @(negedge clk_i);
        check("drop_end", 32'(bus.drop_o), 0);
        check("drop_flit_vld2", 32'(bus.flit_vld_o), 0);
        check("drop_msg_rdy", 32'(bus.msg_rdy_o), 1);
        check("drop_count", drops, 1);
        send_pkt(2'd2, 2'd2, 0, 6'h30);
        drain();
        // back-to-back: six flits, no bubble between packets
        xq.delete();
        send_pkt(2'd1, 2'd1, 1, 6'h01);
        send_pkt(2'd2, 2'd2, 1, 6'h3E);
        drain();
        check("b2b_count", xq.size(), 6);
        if (xq.size() == 6) check("b2b_span", xq[5] - xq[0], 5);
        // reset after first body: packet abandoned
        sb.push_back(8'h01); sb.push_back(8'h45);
        msg(2'd0, 2'd1, 4'd3);
        pld(6'h05);
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("mrst_vld", 32'(bus.flit_vld_o), 0);
        check("mrst_data", 32'(bus.flit_data_o), 0);
        check("mrst_msg_rdy", 32'(bus.msg_rdy_o), 0);
        check("mrst_pld_rdy", 32'(bus.pld_rdy_o), 0);
        check("mrst_sb", sb.size(), 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        send_pkt(2'd2, 2'd0, 0, 6'h2C);
        drain();
        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/mesh_wormhole_packetizer.md
# mesh_wormhole_packetizer

Terminal-side network interface that injects packets into one terminal input channel of the 2D mesh wormhole XY NoC. It accepts a message descriptor (destination coordinates and payload length) and a stream of payload words. It emits a head/body/tail flit sequence on a valid/ready channel that connects directly to the NoC's per-node `ichan_data_i`/`ichan_vld_i`/`ichan_rdy_o` slice. It is the transmit end of the terminal port. Messages with out-of-range destinations are dropped.

## Interface
- `ROW_N`, 3, mesh rows.
- `COL_M`, 3, mesh columns.
- `CHANNEL_W`, 8, flit width including the ID field.
- `FLIT_ID_W`, 2, flit ID field width; fixed.
- `LEN_W`, 4, message length field width.
- Derived values:
  - FLIT_DATA_W = CHANNEL_W − FLIT_ID_W.
  - ROW_ADDR_W = $clog2(ROW_N).
  - COL_ADDR_W = $clog2(COL_M).
  - FLIT_DATA_W ≥ ROW_ADDR_W + COL_ADDR_W is required.
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: synchronous, active-low reset.
- `msg_vld_i` input 1: message descriptor valid.
- `msg_rdy_o` output 1: descriptor accepted when high together with `msg_vld_i`.
- `msg_dst_row_i` input ROW_ADDR_W: destination row.
- `msg_dst_col_i` input COL_ADDR_W: destination column.
- `msg_len_i` input LEN_W: payload word count minus 1, giving 1..2^LEN_W words.
- `pld_vld_i` input 1: payload word valid.
- `pld_rdy_o` output 1: payload word accepted.
- `pld_data_i` input FLIT_DATA_W: payload word.
- `flit_vld_o` output 1: flit valid toward the NoC.
- `flit_rdy_i` input 1: NoC ready.
- `flit_data_o` output CHANNEL_W: flit.
- `drop_o` output 1: one-cycle pulse when a message is dropped.

## Operation
- Flit layout:
  - `flit_data_o[CHANNEL_W-1 -: FLIT_ID_W]` = ID.
  - Low FLIT_DATA_W bits = data.
- ID encoding:
  - HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10.
  - 2'b11 is never emitted.
- Head data = {zero-pad, dst_row, dst_col}, with dst_col in the LSBs.
- Body and tail data carry the payload word unchanged.
- Packet shape for N = msg_len_i + 1 payload words:
  - Flits are HEAD, then N−1 BODY, then TAIL.
  - The tail carries the last word.
  - Minimum packet is HEAD + TAIL.
- Output register: `flit_data_o`/`flit_vld_o` are registered.
  - Define `load_ok = !flit_vld_o || flit_rdy_i`.
  - The register loads a new flit only when load_ok is high.
  - Otherwise data and valid hold stable.
  - A flit transfers when `flit_vld_o && flit_rdy_i`.
- FSM states are IDLE, PAYLOAD and DROP.
- IDLE:
  - `msg_rdy_o = load_ok`.
  - On a descriptor handshake, latch the length into a down-counter `rem` (LEN_W bits).
  - If the destination is in range (dst_row < ROW_N and dst_col < COL_M): load the HEAD flit and go to PAYLOAD.
  - Otherwise: pulse `drop_o` next cycle and go to DROP.
- PAYLOAD:
  - `pld_rdy_o = load_ok`.
  - On each payload handshake:
    - If rem ≠ 0, load a BODY flit and decrement rem.
    - If rem = 0, load the TAIL flit and go to IDLE.
- DROP:
  - `pld_rdy_o = 1`.
  - Consume and discard N words with the same counter, then go to IDLE.
  - No flits are emitted.
- Outside the cases above, `msg_rdy_o` and `pld_rdy_o` are 0.
- The destination may equal the local node; the packet is still sent.
- Reset (rst_ni low at a clock edge):
  - State goes to IDLE, rem = 0.
  - `flit_vld_o` = 0, `flit_data_o` = 0, `drop_o` = 0.
  - `msg_rdy_o` and `pld_rdy_o` are forced to 0 while rst_ni is low.
  - Reset mid-packet abandons the packet: no tail is sent. The NoC is reset together with this block.

## Timing
- Descriptor handshake at edge t: HEAD is valid from t+1.
- Payload handshake at edge t: the corresponding flit is valid from t+1.
- With `flit_rdy_i` held high and a continuous payload supply, one flit transfers per cycle.
- Back-to-back packets:
  - The TAIL is loaded at t and the FSM is in IDLE at t+1.
  - The next descriptor may be accepted at t+1, so its HEAD is valid at t+2.
  - There is no output bubble.
- Backpressure: while `flit_vld_o && !flit_rdy_i`, all ready outputs are 0 and the held flit is stable.
- `drop_o` is high exactly one cycle, the cycle after the dropping descriptor handshake.
- A drop of N words takes at least N cycles in DROP.
- The valid/ready rules are symmetric on all three interfaces:
  - A source never deasserts valid without a handshake.
  - Data is stable while valid is high.
  - Ready may depend on internal state only, never combinationally on the same interface's valid.

## Test plan
- Basic packet (defaults): dst (2,1), len 2, payload 6'h15, 6'h2A, 6'h3F, `flit_rdy_i` = 1 -> flits 8'h09, 8'h55, 8'h6A, 8'hBF on 4 consecutive cycles; HEAD appears 1 cycle after the descriptor handshake.
- Single-word packet: dst (0,0), len 0, payload 6'h01 -> 8'h00 then 8'h81; `msg_rdy_o` returns high the cycle after the tail is loaded.
- Backpressure: hold `flit_rdy_i` low for 5 cycles mid-packet -> the held flit is unchanged, `pld_rdy_o` = 0 throughout, no flit is lost or duplicated, and the sequence completes after release.
- Drop: dst (3,0), len 1, two payload words -> `drop_o` is a single pulse, both words are consumed, `flit_vld_o` stays 0, and the next valid message is sent normally.
- Back-to-back: two 2-word packets with continuous valid and ready -> 6 flits on 6 consecutive cycles, HEAD/TAIL order correct.
- Reset mid-packet: assert rst_ni low after the first BODY flit -> the next cycle shows `flit_vld_o` = 0 and `flit_data_o` = 0 with both ready outputs at 0; after release a fresh packet starts with HEAD.
